ps_readout_arbiter: RTL and testbench
=====================================

# ps_readout_arbiter

Round-robin readout arbiter that drains up to NCH parallel-serial channel FIFOs into one 36-bit output stream toward the control interface. It sits in the control clock domain, on the read side of each channel's fifo36x512. It drives each channel's `fifo_rd_en`, multiplexes `fifo_q`, and optionally frames every burst with a header word tagging the channel. It replaces ad-hoc per-channel polling by software with a fair, back-pressured hardware scheduler.

## Interface
- `NCH`, 4: number of channel FIFOs (1..16).
- `FIFO_WIDTH`, 36: width of channel and output words.
- `MAX_BURST`, 64: maximum data words read from one channel per grant (1..255).
- `clk`  in  1  control clock; same clock as the channel FIFO read side.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  global run; deasserting it finishes the current burst, then idles.
- `chan_mask`  in  NCH  1 = channel eligible for grant.
- `ch_empty`  in  NCH  per-channel FIFO empty.
- `ch_q`  in  NCH*FIFO_WIDTH  per-channel FIFO dout; channel i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- `ch_rd_en`  out  NCH  per-channel FIFO read enable; one-hot or zero.
- `out_afull`  in  1  downstream almost-full; when low, at least 2 free entries are guaranteed.
- `out_data`  out  FIFO_WIDTH  output word.
- `out_valid`  out  1  `out_data` valid this cycle.
- `busy`  out  1  high in any state other than IDLE.
- `cur_chan`  out  4  currently or last granted channel.

## Operation
- States: IDLE, HDR, READ, DRAIN.
- IDLE:
  - When `enable` is high and any channel has `chan_mask[i] & ~ch_empty[i]`, round-robin select the next such channel after `cur_chan`, wrapping from NCH-1 to 0. After reset the search starts at channel 0.
  - Latch the result into `cur_chan`, clear `burst_cnt`, and go to HDR (macro on) or READ (macro off).
- HDR: when `out_afull` is low, emit the header word and go to READ. Otherwise hold.
  - Header bits [35:32] = 4'hC.
  - Bits [31:28] = `cur_chan`.
  - Bits [27:16] = 12-bit grant sequence counter, which wraps and increments per header.
  - Bits [15:0] = 0.
- READ, per cycle:
  - Assert `ch_rd_en[cur_chan]` iff all of these hold: `~ch_empty[cur_chan]`, `~out_afull`, and `burst_cnt < MAX_BURST`. Increment `burst_cnt` on each read.
  - Go to DRAIN when any of these holds: `ch_empty[cur_chan]` is high, `burst_cnt` reaches MAX_BURST, or `chan_mask[cur_chan]` drops.
  - `out_afull` alone stalls; it never ends a burst.
- DRAIN: one cycle for the last in-flight word, then IDLE. Arbitration resumes the following cycle.
- Data words pass through unmodified. `out_data` = `ch_q` of the channel read in the previous cycle.
- Header and data are never valid in the same cycle.
- `enable` low during READ does not abort the burst; the arbiter returns to IDLE normally.

## Timing
- Reset values:
  - `ch_rd_en` = 0, `out_valid` = 0, `out_data` = 0, `busy` = 0, `cur_chan` = NCH-1 (so the first grant goes to channel 0).
  - State = IDLE; sequence counter = 0.
  - Any in-flight read is discarded.
- Read latency: `ch_rd_en` high in cycle t gives `out_valid` high in t+1 with that channel's word. `out_valid` is a registered copy of the OR of `ch_rd_en`.
- Header: `out_valid` is registered, in the cycle after HDR is left.
- Back-to-back reads sustain 1 word/clock while `out_afull` stays low.
- Worst-case overhead per burst: 3 cycles (IDLE, HDR, DRAIN).
- Single eligible channel: it is regranted after DRAIN→IDLE.
- Empty mask or all channels empty: stay in IDLE, `busy` = 0.
- `out_afull` rising in cycle t: no read in t. At most 1 word (issued at t-1) lands after the assertion.

## Configuration
- `PS_ARB_HEADER_EN`: defined compiles in the HDR state and header word.
- Undefined: IDLE goes directly to READ, the output carries raw channel words only, and the sequence counter is removed. Channel identity is then available only via `cur_chan`.

## Structure
- Package `ps_arb_pkg`:
  - State enum.
  - `HDR_MARK` = 4'hC.
  - Header field positions.
  - Sequence-counter width (12).
- Sub-module `rr_pick`: combinational round-robin priority encoder. Inputs are the request vector and the last grant index; outputs are the next grant index and a valid flag.

## Test plan
- **Single channel:** NCH=4, mask=4'b0001, ch0 preloaded with 5 words, header on → header 0xC_0_000_0000 followed by the 5 words in order on consecutive cycles; `busy` low 1 cycle after DRAIN.
- **Round robin:** ch1 and ch3 each hold 3 words, `cur_chan` = 0 → grant order ch1 then ch3; header channel fields 1 then 3; sequence 0 then 1.
- **Burst limit:** MAX_BURST=4, ch2 holds 10 words, only ch2 eligible → bursts of 4, 4, 2, each with its own header; sequence 0, 1, 2.
- **Back-pressure:** `out_afull` pulses high for 3 cycles mid-burst → no `ch_rd_en` during the pulse; at most 1 word after the rising edge; no loss or duplication; order preserved.
- **Mask drop:** clear `chan_mask[cur_chan]` mid-burst → at most 1 further word, then DRAIN and a grant to the next eligible channel.
- **Reset mid-burst:** `rst` asserted during READ → next cycle all outputs at reset values; after release the first grant goes to channel 0 and the sequence counter is 0.

Source files
------------

// File: rtl/ps_arb_pkg.sv
// Shared types and header layout for the parallel-serial readout arbiter.
package ps_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  localparam int unsigned CHAN_W       = 4;
  localparam int unsigned SEQ_W        = 12;
  localparam int unsigned HDR_W        = 36;
  localparam int unsigned HDR_MARK_LSB = 32;
  localparam int unsigned HDR_CHAN_LSB = 28;
  localparam int unsigned HDR_SEQ_LSB  = 16;
  localparam logic [3:0]  HDR_MARK     = 4'hC;

  // Build a burst header word: mark, channel, grant sequence, zero low half
  function automatic logic [HDR_W-1:0] make_hdr(input logic [CHAN_W-1:0] chan,
                                                input logic [SEQ_W-1:0]  seq);
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_MARK_LSB +: 4]      = HDR_MARK;
    h[HDR_CHAN_LSB +: CHAN_W] = chan;
    h[HDR_SEQ_LSB +: SEQ_W]   = seq;
    return h;
  endfunction

endpackage

// File: rtl/ps_readout_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping.
module rr_pick
  import ps_arb_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]    req,
  input  logic [CHAN_W-1:0] last,
  output logic [CHAN_W-1:0] grant,
  output logic              valid
);

  int unsigned off;
  int unsigned best;

  // Keep the requester with the smallest circular distance past 'last'
  always_comb begin
    grant = '0;
    valid = 1'b0;
    best  = NCH;
    off   = 0;
    for (int unsigned j = 0; j < NCH; j++) begin
      off = (j + 2 * NCH - 1 - 32'(last)) % NCH;
      if (req[j] && (off < best)) begin
        best  = off;
        grant = CHAN_W'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps_readout_arbiter.sv
// Round-robin readout arbiter draining NCH channel FIFOs into one output stream.
// Channel FIFOs are show-ahead: ch_q carries the head word while ch_empty is low,
// and the word is captured into out_data on the clock that pops it.
// Optional feature: define PS_ARB_HEADER_EN to frame each burst with a header word.
module ps_readout_arbiter
  import ps_arb_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned FIFO_WIDTH = 36,
  parameter int unsigned MAX_BURST  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NCH-1:0]            chan_mask,
  input  logic [NCH-1:0]            ch_empty,
  input  logic [NCH*FIFO_WIDTH-1:0] ch_q,
  output logic [NCH-1:0]            ch_rd_en,
  input  logic                      out_afull,
  output logic [FIFO_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  output logic                      busy,
  output logic [3:0]                cur_chan
);

  localparam int unsigned BURST_W = 8;

  arb_state_e             state;
  logic [BURST_W-1:0]     burst_cnt;
  logic [CHAN_W-1:0]      pick;
  logic                   pick_valid;
  logic                   head_empty;
  logic                   head_mask;
  logic [FIFO_WIDTH-1:0]  head_q;
  logic                   rd_go;
  logic                   burst_done;
`ifdef PS_ARB_HEADER_EN
  logic [SEQ_W-1:0]       seq;
`endif

  rr_pick #(.NCH(NCH)) u_pick (
    .req   (chan_mask & ~ch_empty),
    .last  (cur_chan),
    .grant (pick),
    .valid (pick_valid)
  );

  // Status and head word of the granted channel
  always_comb begin
    head_empty = 1'b1;
    head_mask  = 1'b0;
    head_q     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (CHAN_W'(i) == cur_chan) begin
        head_empty = ch_empty[i];
        head_mask  = chan_mask[i];
        head_q     = ch_q[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  // Read issue; reacts to empty/afull in the same cycle so no word is ever overrun
  always_comb begin
    rd_go      = !rst && (state == ST_READ) && !head_empty && !out_afull &&
                 (32'(burst_cnt) < MAX_BURST);
    burst_done = (32'(burst_cnt) + 32'(rd_go)) >= MAX_BURST;
    ch_rd_en   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      ch_rd_en[i] = rd_go && (CHAN_W'(i) == cur_chan);
    end
  end

  assign busy = (state != ST_IDLE);

  // Arbitration FSM with registered output word/valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_chan  <= 4'(NCH - 1);
      burst_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef PS_ARB_HEADER_EN
      seq       <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      out_data  <= '0;
      case (state)
        ST_IDLE: begin
          if (enable && pick_valid) begin
            cur_chan  <= pick;
            burst_cnt <= '0;
`ifdef PS_ARB_HEADER_EN
            state     <= ST_HDR;
`else
            state     <= ST_READ;
`endif
          end
        end
`ifdef PS_ARB_HEADER_EN
        ST_HDR: begin
          if (!out_afull) begin
            out_valid <= 1'b1;
            out_data  <= FIFO_WIDTH'(make_hdr(cur_chan, seq));
            seq       <= seq + SEQ_W'(1);
            state     <= ST_READ;
          end
        end
`endif
        ST_READ: begin
          if (rd_go) begin
            out_valid <= 1'b1;
            out_data  <= head_q;
            burst_cnt <= burst_cnt + BURST_W'(1);
          end
          if (head_empty || !head_mask || burst_done) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps_readout_arbiter.sv
// Randomized bench for ps_readout_arbiter against a burst-level stream model.
// Honours PS_ARB_HEADER_EN when predicting header words.
module tb_ps_readout_arbiter;

  localparam int unsigned NCH  = 4;
  localparam int unsigned W    = 36;
  localparam int unsigned MAXB = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [NCH-1:0]   chan_mask;
  logic [NCH-1:0]   ch_empty;
  logic [NCH*W-1:0] ch_q;
  logic [NCH-1:0]   ch_rd_en;
  logic             out_afull;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             busy;
  logic [3:0]       cur_chan;

  always #5 clk = ~clk;

  ps_readout_arbiter #(.NCH(NCH), .FIFO_WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .chan_mask(chan_mask),
    .ch_empty(ch_empty), .ch_q(ch_q), .ch_rd_en(ch_rd_en),
    .out_afull(out_afull), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .cur_chan(cur_chan)
  );

  logic [W-1:0] fifo [NCH][$];
  logic [W-1:0] mdl  [NCH][$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs[$];
  int           obs_cyc[$];
  int           cyc;
  int           n_tests;
  int           n_fail;
  int           m_last;
  logic [11:0]  m_seq;
  int           afull_pct;
  logic         afull_prev;
  int           n_data;
  int           drop_at;
  int           drop_ch;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, expv, cyc);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NCH; i++) begin
      ch_empty[i]    = (fifo[i].size() == 0);
      ch_q[i*W +: W] = ch_empty[i] ? '0 : fifo[i][0];
    end
  endtask

  task automatic preload(input int ch, input int n);
    for (int k = 0; k < n; k++) fifo[ch].push_back({4'h5, 4'(ch), 28'($urandom)});
  endtask

  // Expected stream: repeat round-robin grants over a copy of FIFO contents
  task automatic predict();
    int  g;
    int  n;
    bit  found;
    for (int i = 0; i < NCH; i++) mdl[i] = fifo[i];
    for (int it = 0; it < 1000; it++) begin
      found = 1'b0;
      g     = 0;
      for (int off = 1; off <= NCH; off++) begin
        int c;
        c = (m_last + off) % NCH;
        if (!found && chan_mask[c] && mdl[c].size() > 0) begin
          found = 1'b1;
          g     = c;
        end
      end
      if (found) begin
        m_last = g;
`ifdef PS_ARB_HEADER_EN
        exp_q.push_back({4'hC, 4'(g), m_seq, 16'h0});
        m_seq = m_seq + 12'd1;
`endif
        n = (mdl[g].size() < MAXB) ? mdl[g].size() : MAXB;
        for (int k = 0; k < n; k++) exp_q.push_back(mdl[g].pop_front());
      end
    end
  endtask

  task automatic start(input logic [NCH-1:0] mask);
    chan_mask = mask;
    obs.delete();
    obs_cyc.delete();
    exp_q.delete();
    predict();
    refresh();
  endtask

  task automatic cycle();
    logic [NCH-1:0] rd;
    @(negedge clk);
    cyc++;
    if (out_valid) begin
      obs.push_back(out_data);
      obs_cyc.push_back(cyc);
      if (out_data[35:32] == 4'h5) n_data++;
    end
    chk("valid_after_afull", 64'(out_valid & afull_prev), 64'(0));
    if (drop_at >= 0 && n_data >= drop_at) begin
      chan_mask[drop_ch] = 1'b0;
      drop_at = -1;
    end
    out_afull  = ($urandom_range(99) < afull_pct);
    afull_prev = out_afull;
    #1;
    rd = ch_rd_en;
    chk("rd_onehot", 64'($countones(rd) <= 1), 64'(1));
    chk("rd_under_afull", 64'((|rd) & out_afull), 64'(0));
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (rd[i]) begin
        if (fifo[i].size() == 0) chk("rd_from_empty", 64'(1), 64'(0));
        else void'(fifo[i].pop_front());
      end
    end
    refresh();
  endtask

  task automatic run_expect(input string tag, input int budget);
    bit done;
    int n;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      cycle();
      if (obs.size() >= exp_q.size() && !busy) done = 1'b1;
    end
    chk({tag, "_timeout"}, 64'(done), 64'(1));
    repeat (3) cycle();
    chk({tag, "_len"}, 64'(obs.size()), 64'(exp_q.size()));
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_word"}, 64'(obs[i]), 64'(exp_q[i]));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_chan"}, 64'(cur_chan), 64'(m_last));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"},     64'(ch_rd_en),  64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_data"},  64'(out_data),  64'(0));
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_cur_chan"},  64'(cur_chan),  64'(NCH - 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] snap_d[$];
    logic [W-1:0] snap_o[$];
    logic [W-1:0] dat[$];
    int           other;
    int           n0;
    int           n1;

    n_tests = 0; n_fail = 0; cyc = 0; n_data = 0; drop_at = -1; drop_ch = 0;
    rst = 1'b1; enable = 1'b0; chan_mask = '0; out_afull = 1'b0;
    afull_pct = 0; afull_prev = 1'b0; ch_q = '0; ch_empty = '1;
    m_last = NCH - 1; m_seq = '0;

    repeat (3) cycle();
    check_reset_outputs("reset");
    rst = 1'b0;

    // enable low: data present but nothing may be granted
    preload(0, 4);
    start(4'b0001);
    repeat (8) cycle();
    chk("en_low_no_output", 64'(obs.size()), 64'(0));
    chk("en_low_idle", 64'(busy), 64'(0));

    // single channel, no back-pressure: one burst on consecutive cycles
    enable = 1'b1;
    run_expect("single", 200);
    if (obs_cyc.size() > 0)
      chk("single_b2b", 64'(obs_cyc[obs_cyc.size()-1] - obs_cyc[0]), 64'(obs_cyc.size() - 1));

    // round robin between channels 1 and 3
    preload(1, 3);
    preload(3, 3);
    start(4'b1111);
    run_expect("rr", 300);

    // burst limit on a single deep channel
    preload(2, 10);
    start(4'b0100);
    run_expect("burst", 300);

    // random back-pressure over two channels
    preload(0, 8);
    preload(1, 5);
    afull_pct = 40;
    start(4'b0011);
    run_expect("bp", 600);

    // randomized fills, masks and back-pressure
    for (int r = 0; r < 6; r++) begin
      for (int ch = 0; ch < NCH; ch++) preload(ch, $urandom_range(0, 9));
      afull_pct = $urandom_range(0, 50);
      start(4'($urandom_range(1, 15)));
      run_expect("rand", 2000);
    end
    afull_pct = 0;
    start(4'b1111);
    run_expect("flush", 2000);

    // mask drop mid-burst
    drop_ch = (m_last == 0) ? 1 : 0;
    other   = 1 - drop_ch;
    preload(drop_ch, 6);
    preload(other, 2);
    snap_d = fifo[drop_ch];
    snap_o = fifo[other];
    chan_mask = 4'b0011;
    obs.delete();
    n_data  = 0;
    drop_at = 2;
    refresh();
    repeat (60) cycle();
    dat.delete();
    foreach (obs[i]) if (obs[i][35:32] == 4'h5) dat.push_back(obs[i]);
    n0 = 0;
    while (n0 < dat.size() && dat[n0][31:28] == 4'(drop_ch)) n0++;
    n1 = dat.size() - n0;
    chk("drop_len_ok", 64'(n0 >= 2 && n0 <= 3), 64'(1));
    chk("drop_next_cnt", 64'(n1), 64'(2));
    chk("drop_left", 64'(fifo[drop_ch].size()), 64'(6 - n0));
    for (int i = 0; i < n0 && i < 6; i++) chk("drop_word", 64'(dat[i]), 64'(snap_d[i]));
    for (int j = 0; j < n1 && j < 2; j++) chk("drop_next_word", 64'(dat[n0+j]), 64'(snap_o[j]));
    chk("drop_chan", 64'(cur_chan), 64'(other));
    m_last = other;
`ifdef PS_ARB_HEADER_EN
    m_seq = m_seq + 12'd2;
`endif
    start(4'b0011);
    run_expect("drop_rest", 300);

    // reset in the middle of a burst
    preload(2, 8);
    preload(0, 2);
    start(4'b0100);
    repeat (5) cycle();
    rst = 1'b1;
    cycle();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    m_last = NCH - 1;
    m_seq  = '0;
    start(4'b0101);
    run_expect("post_reset", 500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
